// File: rtl/regfile_sb.sv
// regfile_sb: general-purpose register file with NREAD combinational read
// ports, two write ports and an integrated load-use scoreboard.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   we0/waddr0/wdata0        write port 0 (ALU writeback, wins collisions)
//   we1/waddr1/wdata1        write port 1 (load writeback, releases busy)
//   re, raddr                per-port read enable and packed read addresses
//   rdata, rready            per-port read data (with bypass) and operand valid
//   alloc_en, alloc_addr     mark a register busy (load issued)
//   flush                    clear all busy bits
//   busy_cnt                 registered count of busy registers
//   alloc_err                sticky flag: alloc to an already-busy register
module regfile_sb #(
    parameter int unsigned DW    = 32,
    parameter int unsigned AW    = 5,
    parameter int unsigned NREAD = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we0,
    input  logic [AW-1:0]         waddr0,
    input  logic [DW-1:0]         wdata0,
    input  logic                  we1,
    input  logic [AW-1:0]         waddr1,
    input  logic [DW-1:0]         wdata1,
    input  logic [NREAD-1:0]      re,
    input  logic [NREAD*AW-1:0]   raddr,
    output logic [NREAD*DW-1:0]   rdata,
    output logic [NREAD-1:0]      rready,
    input  logic                  alloc_en,
    input  logic [AW-1:0]         alloc_addr,
    input  logic                  flush,
    output logic [AW:0]           busy_cnt,
    output logic                  alloc_err
);

    localparam int unsigned NREG = 1 << AW;

    logic [DW-1:0]   regs [NREG];
    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_nxt;
    logic            err_nxt;

    function automatic logic [AW:0] popcount(input logic [NREG-1:0] v);
        logic [AW:0] c;
        c = '0;
        for (int r = 0; r < NREG; r++) begin
            c = c + (AW+1)'(v[r]);
        end
        return c;
    endfunction

    // Register array; port 0 assigned last so it wins a same-address collision.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++) begin
                regs[r] <= '0;
            end
        end else begin
            if (we1 && (waddr1 != '0)) begin
                regs[waddr1] <= wdata1;
            end
            if (we0 && (waddr0 != '0)) begin
                regs[waddr0] <= wdata0;
            end
        end
    end

    // Read ports with same-cycle writeback bypass; a port-1 write also
    // makes a busy operand ready in the cycle it lands.
    always_comb begin
        rdata  = '0;
        rready = '0;
        for (int i = 0; i < NREAD; i++) begin
            if (!rst && re[i]) begin
                rready[i] = (raddr[i*AW +: AW] == '0)
                          || !busy[raddr[i*AW +: AW]]
                          || (we1 && (waddr1 == raddr[i*AW +: AW]));
                if (raddr[i*AW +: AW] != '0) begin
                    if (we0 && (waddr0 == raddr[i*AW +: AW])) begin
                        rdata[i*DW +: DW] = wdata0;
                    end else if (we1 && (waddr1 == raddr[i*AW +: AW])) begin
                        rdata[i*DW +: DW] = wdata1;
                    end else begin
                        rdata[i*DW +: DW] = regs[raddr[i*AW +: AW]];
                    end
                end
            end
        end
    end

    // Scoreboard next state: flush, then alloc, then release.
    always_comb begin
        busy_nxt = busy;
        err_nxt  = alloc_err;
        if (flush) begin
            busy_nxt = '0;
        end else begin
            if (we1 && (waddr1 != '0)) begin
                busy_nxt[waddr1] = 1'b0;
            end
            if (alloc_en && (alloc_addr != '0)) begin
                // Re-alloc is legal only if the older load retires this cycle.
                if (busy[alloc_addr] && !(we1 && (waddr1 == alloc_addr))) begin
                    err_nxt = 1'b1;
                end
                busy_nxt[alloc_addr] = 1'b1;
            end
        end
    end

    // Scoreboard state; busy_cnt tracks the popcount of the new busy vector.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy      <= '0;
            busy_cnt  <= '0;
            alloc_err <= 1'b0;
        end else begin
            busy      <= busy_nxt;
            busy_cnt  <= popcount(busy_nxt);
            alloc_err <= err_nxt;
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: self-checking bench for regfile_sb (NREAD=4) with directed
// scenarios and a randomized run against a behavioural register/scoreboard model.
module tb_regfile_sb;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;
    localparam int unsigned NR = 4;

    logic              clk;
    logic              rst;
    logic              we0, we1;
    logic [AW-1:0]     waddr0, waddr1;
    logic [DW-1:0]     wdata0, wdata1;
    logic [NR-1:0]     re;
    logic [NR*AW-1:0]  raddr;
    logic [NR*DW-1:0]  rdata;
    logic [NR-1:0]     rready;
    logic              alloc_en;
    logic [AW-1:0]     alloc_addr;
    logic              flush;
    logic [AW:0]       busy_cnt;
    logic              alloc_err;

    int checks   = 0;
    int failures = 0;

    // Behavioural model state
    logic [DW-1:0] mregs [32];
    bit            mbusy [32];
    bit            merr;

    regfile_sb #(.DW(DW), .AW(AW), .NREAD(NR)) dut (
        .clk(clk), .rst(rst),
        .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
        .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
        .re(re), .raddr(raddr), .rdata(rdata), .rready(rready),
        .alloc_en(alloc_en), .alloc_addr(alloc_addr), .flush(flush),
        .busy_cnt(busy_cnt), .alloc_err(alloc_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [DW-1:0] exp_data(int i);
        logic [AW-1:0] a;
        a = raddr[i*AW +: AW];
        if (rst || !re[i] || a == 0) return '0;
        if (we0 && waddr0 == a) return wdata0;
        if (we1 && waddr1 == a) return wdata1;
        return mregs[a];
    endfunction

    function automatic logic exp_rdy(int i);
        logic [AW-1:0] a;
        a = raddr[i*AW +: AW];
        if (rst || !re[i]) return 1'b0;
        return (a == 0) || !mbusy[a] || (we1 && waddr1 == a);
    endfunction

    function automatic int exp_cnt();
        int c = 0;
        for (int r = 0; r < 32; r++) c += int'(mbusy[r]);
        return c;
    endfunction

    task automatic idle();
        we0 = 0; we1 = 0; waddr0 = 0; waddr1 = 0; wdata0 = 0; wdata1 = 0;
        re = 0; raddr = 0; alloc_en = 0; alloc_addr = 0; flush = 0;
    endtask

    task automatic rd(int i, logic [AW-1:0] a);
        re[i] = 1'b1;
        raddr[i*AW +: AW] = a;
    endtask

    // Advance one clock: compute the model's next state from the held inputs.
    task automatic adv();
        logic [DW-1:0] nregs [32];
        bit            nbusy [32];
        bit            nerr;
        nregs = mregs; nbusy = mbusy; nerr = merr;
        if (we1 && waddr1 != 0) nregs[waddr1] = wdata1;
        if (we0 && waddr0 != 0) nregs[waddr0] = wdata0;
        if (flush) begin
            for (int r = 0; r < 32; r++) nbusy[r] = 0;
        end else begin
            if (we1 && waddr1 != 0) nbusy[waddr1] = 0;
            if (alloc_en && alloc_addr != 0) begin
                if (mbusy[alloc_addr] && !(we1 && waddr1 == alloc_addr)) nerr = 1;
                nbusy[alloc_addr] = 1;
            end
        end
        @(posedge clk);
        mregs = nregs; mbusy = nbusy; merr = nerr;
        #1;
    endtask

    task automatic model_clear();
        for (int r = 0; r < 32; r++) begin
            mregs[r] = '0;
            mbusy[r] = 0;
        end
        merr = 0;
    endtask

    task automatic test_reset();
        idle();
        we0 = 1; waddr0 = 5; wdata0 = 32'h5555_AAAA;
        alloc_en = 1; alloc_addr = 6;
        adv();
        idle();
        re = '1; raddr = {5'd6, 5'd5, 5'd0, 5'd5};
        rst = 1'b1;
        #2;
        model_clear();
        checks++;
        if (rdata !== '0) begin
            failures++; $display("FAIL reset_rdata got=%h exp=0", rdata);
        end
        checks++;
        if (rready !== 4'b0000) begin
            failures++; $display("FAIL reset_rready got=%b exp=0000", rready);
        end
        checks++;
        if (busy_cnt !== 6'd0 || alloc_err !== 1'b0) begin
            failures++; $display("FAIL reset_sb got cnt=%0d err=%b exp cnt=0 err=0", busy_cnt, alloc_err);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (rdata[31:0] !== 32'h0 || rready !== 4'b1111) begin
            failures++; $display("FAIL reset_r5 got data=%h rdy=%b exp data=0 rdy=1111", rdata[31:0], rready);
        end
        adv();
        idle();
    endtask

    task automatic test_write_bypass();
        idle();
        we0 = 1; waddr0 = 3; wdata0 = 32'hDEAD_BEEF; rd(0, 3);
        #1;
        checks++;
        if (rdata[31:0] !== 32'hDEAD_BEEF || rready[0] !== 1'b1) begin
            failures++; $display("FAIL bypass0 got data=%h rdy=%b exp data=deadbeef rdy=1", rdata[31:0], rready[0]);
        end
        adv();
        we0 = 0;
        #1;
        checks++;
        if (rdata[31:0] !== 32'hDEAD_BEEF) begin
            failures++; $display("FAIL array_r3 got=%h exp=deadbeef", rdata[31:0]);
        end
        we0 = 1; waddr0 = 0; wdata0 = 32'h1234; rd(0, 0);
        adv();
        we0 = 0;
        #1;
        checks++;
        if (rdata[31:0] !== 32'h0 || rready[0] !== 1'b1) begin
            failures++; $display("FAIL r0_zero got data=%h rdy=%b exp data=0 rdy=1", rdata[31:0], rready[0]);
        end
        idle();
    endtask

    task automatic test_collision();
        idle();
        we0 = 1; waddr0 = 7; wdata0 = 32'h11;
        we1 = 1; waddr1 = 7; wdata1 = 32'h22;
        rd(1, 7);
        #1;
        checks++;
        if (rdata[63:32] !== 32'h11) begin
            failures++; $display("FAIL collide_bypass got=%h exp=11", rdata[63:32]);
        end
        adv();
        we0 = 0; we1 = 0;
        #1;
        checks++;
        if (rdata[63:32] !== 32'h11) begin
            failures++; $display("FAIL collide_array got=%h exp=11", rdata[63:32]);
        end
        idle();
    endtask

    task automatic test_load_use();
        idle();
        alloc_en = 1; alloc_addr = 9; rd(2, 9);
        #1;
        checks++;
        if (rready[2] !== 1'b1) begin
            failures++; $display("FAIL alloc_cycle_rdy got=%b exp=1", rready[2]);
        end
        adv();
        alloc_en = 0;
        #1;
        checks++;
        if (rready[2] !== 1'b0 || busy_cnt !== 6'd1) begin
            failures++; $display("FAIL load_busy got rdy=%b cnt=%0d exp rdy=0 cnt=1", rready[2], busy_cnt);
        end
        we1 = 1; waddr1 = 9; wdata1 = 32'hAB;
        #1;
        checks++;
        if (rready[2] !== 1'b1 || rdata[95:64] !== 32'hAB) begin
            failures++; $display("FAIL load_release got rdy=%b data=%h exp rdy=1 data=ab", rready[2], rdata[95:64]);
        end
        adv();
        we1 = 0;
        #1;
        checks++;
        if (busy_cnt !== 6'd0 || rready[2] !== 1'b1) begin
            failures++; $display("FAIL load_done got cnt=%0d rdy=%b exp cnt=0 rdy=1", busy_cnt, rready[2]);
        end
        idle();
    endtask

    task automatic test_alloc_release_same();
        idle();
        alloc_en = 1; alloc_addr = 10;
        adv();
        we1 = 1; waddr1 = 10; wdata1 = 32'h77;
        adv();
        idle();
        rd(0, 10);
        #1;
        checks++;
        if (busy_cnt !== 6'd1 || alloc_err !== 1'b0 || rready[0] !== 1'b0) begin
            failures++; $display("FAIL alloc_release got cnt=%0d err=%b rdy=%b exp cnt=1 err=0 rdy=0",
                                 busy_cnt, alloc_err, rready[0]);
        end
        we1 = 1; waddr1 = 10; wdata1 = 32'h78;
        adv();
        idle();
    endtask

    task automatic test_err_flush();
        idle();
        alloc_en = 1; alloc_addr = 4;
        adv();
        adv();
        alloc_en = 0;
        #1;
        checks++;
        if (alloc_err !== 1'b1) begin
            failures++; $display("FAIL alloc_err_set got=%b exp=1", alloc_err);
        end
        alloc_en = 1; alloc_addr = 5; adv();
        alloc_addr = 6; adv();
        alloc_en = 0;
        #1;
        checks++;
        if (busy_cnt !== 6'd3) begin
            failures++; $display("FAIL pre_flush_cnt got=%0d exp=3", busy_cnt);
        end
        flush = 1; alloc_en = 1; alloc_addr = 7;
        adv();
        idle();
        rd(0, 4); rd(1, 5); rd(2, 6); rd(3, 7);
        #1;
        checks++;
        if (busy_cnt !== 6'd0 || rready !== 4'b1111) begin
            failures++; $display("FAIL flush got cnt=%0d rdy=%b exp cnt=0 rdy=1111", busy_cnt, rready);
        end
        checks++;
        if (alloc_err !== 1'b1) begin
            failures++; $display("FAIL alloc_err_sticky got=%b exp=1", alloc_err);
        end
        idle();
    endtask

    task automatic test_multi_port();
        idle();
        we0 = 1; waddr0 = 1; wdata0 = 32'hA1A1_0001;
        we1 = 1; waddr1 = 2; wdata1 = 32'hB2B2_0002;
        alloc_en = 1; alloc_addr = 8;
        adv();
        idle();
        rd(0, 1); rd(1, 2); rd(2, 0); rd(3, 8);
        #1;
        checks++;
        if (rdata[31:0] !== 32'hA1A1_0001 || rdata[63:32] !== 32'hB2B2_0002 || rdata[95:64] !== 32'h0) begin
            failures++; $display("FAIL multi_data got=%h", rdata);
        end
        checks++;
        if (rready !== 4'b0111) begin
            failures++; $display("FAIL multi_rdy got=%b exp=0111", rready);
        end
        flush = 1;
        adv();
        idle();
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            we0 = ($urandom_range(0, 2) == 0);
            we1 = ($urandom_range(0, 2) == 0);
            waddr0 = AW'($urandom_range(0, 15));
            waddr1 = AW'($urandom_range(0, 15));
            wdata0 = $urandom;
            wdata1 = $urandom;
            re = NR'($urandom);
            raddr = {AW'($urandom_range(0, 15)), AW'($urandom_range(0, 15)),
                     AW'($urandom_range(0, 15)), AW'($urandom_range(0, 15))};
            alloc_en = ($urandom_range(0, 2) == 0);
            alloc_addr = AW'($urandom_range(0, 15));
            flush = ($urandom_range(0, 30) == 0);
            #1;
            for (int i = 0; i < NR; i++) begin
                checks++;
                if (rdata[i*DW +: DW] !== exp_data(i) || rready[i] !== exp_rdy(i)) begin
                    failures++;
                    $display("FAIL rand_read it=%0d port=%0d got data=%h rdy=%b exp data=%h rdy=%b",
                             n, i, rdata[i*DW +: DW], rready[i], exp_data(i), exp_rdy(i));
                end
            end
            checks++;
            if (int'(busy_cnt) != exp_cnt() || alloc_err !== merr) begin
                failures++;
                $display("FAIL rand_sb it=%0d got cnt=%0d err=%b exp cnt=%0d err=%b",
                         n, busy_cnt, alloc_err, exp_cnt(), merr);
            end
            adv();
        end
        idle();
    endtask

    initial begin
        idle();
        model_clear();
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        test_reset();
        test_write_bypass();
        test_collision();
        test_load_use();
        test_alloc_release_same();
        test_multi_port();
        test_err_flush();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised general-purpose register file with NREAD read ports, two write ports and an integrated load-use scoreboard. It sits between decode (read/allocate) and the two writeback paths: ALU writeback on port 0, late load/multi-cycle writeback on port 1. Register 0 is hardwired to zero. Per-register busy bits tell decode whether a read operand is valid, so the pipeline can stall without a separate hazard unit.

## Interface
- DW, 32, data width
- AW, 5, address width; 2**AW registers
- NREAD, 2, number of read ports (1..4)
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- we0  in  1  write enable, port 0 (ALU writeback)
- waddr0  in  AW  write address, port 0
- wdata0  in  DW  write data, port 0
- we1  in  1  write enable, port 1 (load writeback; also releases busy)
- waddr1  in  AW  write address, port 1
- wdata1  in  DW  write data, port 1
- re  in  NREAD  per-port read enable
- raddr  in  NREAD*AW  read addresses, port i at [i*AW +: AW]
- rdata  out  NREAD*DW  read data, port i at [i*DW +: DW]
- rready  out  NREAD  operand i valid this cycle
- alloc_en  in  1  mark alloc_addr pending (load issued)
- alloc_addr  in  AW  register to mark busy
- flush  in  1  clear all busy bits
- busy_cnt  out  AW+1  number of registers currently busy
- alloc_err  out  1  sticky: alloc to an already-busy register

## Operation
- Reset (async): all registers, busy bits, busy_cnt, alloc_err cleared to 0. While rst high: rdata=0, rready=0.
- Writes: on clk edge, weN && waddrN!=0 updates regs[waddrN]. Same address on both ports in one cycle: port 0 data wins (port 0 carries the younger instruction).
- Reads (combinational) per port i:
  - re[i]==0 or raddr==0: rdata=0, rready=re[i].
  - else if we0 && waddr0==raddr: rdata=wdata0 (bypass).
  - else if we1 && waddr1==raddr: rdata=wdata1 (bypass).
  - else rdata=regs[raddr].
  - rready[i] = re[i] && (raddr==0 || !busy[raddr] || (we1 && waddr1==raddr)).
- Scoreboard, per register r (r!=0), next-state priority:
  1. flush: busy[r]=0.
  2. alloc_en && alloc_addr==r: busy[r]=1; if busy[r] already 1 and no same-cycle release of r, alloc_err set (sticky until rst).
  3. we1 && waddr1==r: busy[r]=0.
  - Writes on port 0 never touch busy bits.
  - alloc_addr==0 and waddr1==0 have no scoreboard effect.
- busy_cnt: registered population count of busy; equals popcount(busy) every cycle; max 2**AW-1.

## Timing
- Write latency: wdata visible via bypass same cycle, from array next cycle.
- Alloc to busy: 1 cycle; a read of alloc_addr in the alloc cycle still sees old busy (rready follows old state).
- Release: rready high in the same cycle as we1 to that register (bypass).
- Alloc and release of same register in one cycle: ends busy; alloc_err not set.
- flush and alloc in one cycle: all busy cleared, including alloc target; busy_cnt=0 next cycle.
- rst asserted mid-operation: all state cleared immediately, no clock needed; first write accepted on first edge after deassertion.

## Test plan
- Reset: assert rst with regs preloaded -> rdata=0, rready=0, busy_cnt=0, alloc_err=0; after release read r5 -> 0.
- Write/bypass: we0 r3=0xDEADBEEF, re0 raddr r3 same cycle -> rdata=0xDEADBEEF, rready=1; next cycle array read same value; write r0=0x1234 -> r0 reads 0.
- Dual-write collision: we0 r7=0x11, we1 r7=0x22 same cycle -> bypass read 0x11, array r7=0x11 next cycle.
- Load-use: alloc r9 -> next cycle rready=0 for raddr r9, busy_cnt=1; we1 r9=0xAB -> rready=1, rdata=0xAB same cycle; busy_cnt=0 next cycle.
- Error/flush: alloc r4 twice on consecutive cycles -> alloc_err=1 and stays 1; alloc r4,r5,r6 then flush -> busy_cnt=0, all rready=1.
- NREAD=4: four ports read r1,r2,r0,busy r8 concurrently -> independent rdata, rready=1,1,1,0.
